dmu_sii_inb_checker: RTL
========================

DMU_SII_INB_CHECKER -- requirements
Module: dmu_sii_inb_checker

Interface
REQ-001 Parameter DATA_W, default 128: DMU-to-SII data bus width; multiple of 16.
REQ-002 Parameter WR_BEATS, default 4: payload beats following a DMA write header.
REQ-003 Parameter CREDITS, default 16: initial and maximum DMA write credits.
REQ-004 Parameter CNT_W, default 32: width of each transaction counter.
REQ-005 Parameter TAG_W, default 4: width of the write-ack tag.
REQ-006 iol2clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_l  in  1  reset; asynchronous, active-low.
REQ-008 enable  in  1  when low, state, counters and errors hold.
REQ-009 cnt_clr  in  1  synchronous clear of the counters and err_sticky.
REQ-010 dmu_sii_hdr_vld  in  1  header cycle.
REQ-011 dmu_sii_reqbypass  in  1  bypass-queue select; sampled on header cycles.
REQ-012 dmu_sii_datareq  in  1  request carries payload.
REQ-013 dmu_sii_datareq16  in  1  payload is a single 16-byte beat.
REQ-014 dmu_sii_data  in  DATA_W  header or payload data.
REQ-015 dmu_sii_parity  in  DATA_W/16  per-16-bit-lane parity.
REQ-016 sii_dmu_wrack_vld  in  1  write-ack; returns one credit.
REQ-017 sii_dmu_wrack_tag  in  TAG_W  ack tag; not checked.
REQ-018 rd_cnt, wr_cnt, mondo_cnt, pio_cnt  out  CNT_W each  transaction counts.
REQ-019 credit_avail  out  clog2(CREDITS+1)  current write credits.
REQ-020 state  out  2  00 IDLE, 01 WR_PAY, 10 SH_PAY.
REQ-021 err_pulse  out  4  one-cycle error flags: [0] parity, [1] proto, [2] credit underflow, [3] credit overflow.
REQ-022 err_sticky  out  4  OR-accumulated err_pulse.

Function
REQ-023 Header decode with hdr_vld=1 (datareq, datareq16):
  - 0,0: DMA read; rd_cnt+1.
  - 1,0: DMA write; wr_cnt+1; enter WR_PAY with beat count 0.
  - 1,1 with reqbypass=0: Mondo; mondo_cnt+1; enter SH_PAY.
  - 1,1 with reqbypass=1: PIO read return; pio_cnt+1; enter SH_PAY.
  - 0,1: illegal; err_pulse[1]; no counter change; stay in or return to IDLE.
REQ-024 WR_PAY consumes exactly WR_BEATS consecutive cycles, starting the cycle after the header; it returns to IDLE on the cycle after the last beat.
REQ-025 SH_PAY consumes exactly one beat, then returns to IDLE.
REQ-026 hdr_vld=1 during WR_PAY or SH_PAY:
  - err_pulse[1] is raised;
  - the pending payload is abandoned;
  - the new header is decoded normally, as REQ-023.
REQ-027 Parity is checked on every header and payload beat. Expected parity[i] = XOR of data[16i+15:16i]. Any mismatching lane raises err_pulse[0] in the cycle after the beat.
REQ-028 Credits:
  - a DMA write header decrements credit_avail;
  - wrack_vld increments it;
  - both in the same cycle leave it unchanged.
REQ-029 A write header while credit_avail=0 raises err_pulse[2]; credit_avail stays 0; the write is still counted and its payload tracked.
REQ-030 wrack_vld while credit_avail=CREDITS (with no simultaneous write header) raises err_pulse[3]; credit_avail stays CREDITS.
REQ-031 Counters saturate at all-ones and never wrap.
REQ-032 cnt_clr clears the counters and err_sticky next cycle. It does not affect state or credit_avail. A count or error in the same cycle is lost.
REQ-033 err_pulse is registered and asserts for one cycle per detecting beat. Multiple bits may assert together.
REQ-034 enable=0: inputs ignored; all registers hold; err_pulse=0.
REQ-035 All outputs are registered; decode-to-output latency is one cycle.

Reset
REQ-036 While rst_l=0, and immediately on its assertion:
  - state=IDLE;
  - all counters=0;
  - credit_avail=CREDITS;
  - err_pulse=0 and err_sticky=0.
REQ-037 Reset mid-payload abandons the payload without flagging an error.
REQ-038 The first header is accepted on the first rising edge after rst_l deasserts.

Verification
REQ-039 Write header (datareq=1, datareq16=0), good parity, 4 payload beats -> wr_cnt=1, credit_avail=15, state 01 for 4 cycles then 00, err_sticky=0.
REQ-040 16 writes without ack, then a 17th -> credit_avail=0 and err_pulse=4'b0100; then 17 wrack_vld -> credit_avail=16 and err_pulse=4'b1000 on the 17th ack.
REQ-041 Write header and wrack_vld in the same cycle, starting from credit_avail=16 -> credit_avail=16, no error.
REQ-042 Mondo header, then a read header on the payload cycle -> mondo_cnt=1, rd_cnt=1, err_pulse=4'b0010, state=00.
REQ-043 PIO return (reqbypass=1) with parity lane 3 flipped on the payload beat -> pio_cnt=1, err_pulse=4'b0001 one cycle later, err_sticky[0]=1.
REQ-044 rst_l pulsed low during write beat 2 -> state=00 and credit_avail=16 immediately; no error raised after release.

Source files
------------

// File: rtl/dmu_sii_inb_checker.sv
// Inbound DMU-to-SII request checker: decodes headers, tracks payload beats,
// checks per-lane parity and DMA write credits, and keeps saturating counts.
module dmu_sii_inb_checker #(
    parameter int DATA_W   = 128,
    parameter int WR_BEATS = 4,
    parameter int CREDITS  = 16,
    parameter int CNT_W    = 32,
    parameter int TAG_W    = 4
) (
    input  logic                         iol2clk,
    input  logic                         rst_l,
    input  logic                         enable,
    input  logic                         cnt_clr,
    input  logic                         dmu_sii_hdr_vld,
    input  logic                         dmu_sii_reqbypass,
    input  logic                         dmu_sii_datareq,
    input  logic                         dmu_sii_datareq16,
    input  logic [DATA_W-1:0]            dmu_sii_data,
    input  logic [DATA_W/16-1:0]         dmu_sii_parity,
    input  logic                         sii_dmu_wrack_vld,
    input  logic [TAG_W-1:0]             sii_dmu_wrack_tag,
    output logic [CNT_W-1:0]             rd_cnt,
    output logic [CNT_W-1:0]             wr_cnt,
    output logic [CNT_W-1:0]             mondo_cnt,
    output logic [CNT_W-1:0]             pio_cnt,
    output logic [$clog2(CREDITS+1)-1:0] credit_avail,
    output logic [1:0]                   state,
    output logic [3:0]                   err_pulse,
    output logic [3:0]                   err_sticky
);
    localparam int LANES  = DATA_W / 16;
    localparam int CRD_W  = $clog2(CREDITS + 1);
    localparam int BEAT_W = $clog2(WR_BEATS + 1);
    localparam logic [CRD_W-1:0]  CRD_MAX   = CRD_W'(CREDITS);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WR_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WR_PAY = 2'b01,
        ST_SH_PAY = 2'b10
    } state_e;

    state_e            r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [CRD_W-1:0]  r_credit;
    logic [CNT_W-1:0]  r_rd_cnt, r_wr_cnt, r_mondo_cnt, r_pio_cnt;
    logic [3:0]        r_err_pulse, r_err_sticky;

    logic [LANES-1:0] w_par_calc;
    logic w_beat, w_par_err, w_proto, w_underflow, w_overflow;
    logic w_is_rd, w_is_wr, w_is_sh, w_is_ill, w_is_mondo, w_is_pio;
    logic [3:0] w_err;
    logic w_unused_tag;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        // NOTE: default first so every bit is assigned on every pass; no latch is inferred.
        w_par_calc = '0;
        for (int i = 0; i < LANES; i++) begin
            w_par_calc[i] = ^dmu_sii_data[16*i +: 16];
        end
    end

    // Headers are checked in any state; payload beats are any non-idle cycle.
    assign w_beat     = dmu_sii_hdr_vld | (r_state != ST_IDLE);
    assign w_par_err  = w_beat & (|(w_par_calc ^ dmu_sii_parity));

    assign w_is_rd    = dmu_sii_hdr_vld & ~dmu_sii_datareq & ~dmu_sii_datareq16;
    assign w_is_wr    = dmu_sii_hdr_vld &  dmu_sii_datareq & ~dmu_sii_datareq16;
    assign w_is_sh    = dmu_sii_hdr_vld &  dmu_sii_datareq &  dmu_sii_datareq16;
    assign w_is_ill   = dmu_sii_hdr_vld & ~dmu_sii_datareq &  dmu_sii_datareq16;
    assign w_is_mondo = w_is_sh & ~dmu_sii_reqbypass;
    assign w_is_pio   = w_is_sh &  dmu_sii_reqbypass;

    assign w_proto     = w_is_ill | (dmu_sii_hdr_vld & (r_state != ST_IDLE));
    assign w_underflow = w_is_wr & ~sii_dmu_wrack_vld & (r_credit == '0);
    assign w_overflow  = sii_dmu_wrack_vld & ~w_is_wr & (r_credit == CRD_MAX);
    assign w_err       = {w_overflow, w_underflow, w_proto, w_par_err};

    assign w_unused_tag = ^sii_dmu_wrack_tag;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_credit     <= CRD_MAX;
            r_rd_cnt     <= '0;
            r_wr_cnt     <= '0;
            r_mondo_cnt  <= '0;
            r_pio_cnt    <= '0;
            r_err_pulse  <= '0;
            r_err_sticky <= '0;
        end else if (enable) begin
            if (dmu_sii_hdr_vld) begin
                // A new header always wins; any pending payload is dropped.
                r_beat <= '0;
                if (w_is_wr)      r_state <= ST_WR_PAY;
                else if (w_is_sh) r_state <= ST_SH_PAY;
                else              r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_WR_PAY: begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == BEAT_LAST) r_state <= ST_IDLE;
                    end
                    ST_SH_PAY: r_state <= ST_IDLE;
                    default:   r_state <= ST_IDLE;
                endcase
            end

            if (w_is_wr && !sii_dmu_wrack_vld && (r_credit != '0))
                r_credit <= r_credit - 1'b1;
            else if (sii_dmu_wrack_vld && !w_is_wr && (r_credit != CRD_MAX))
                r_credit <= r_credit + 1'b1;

            if (cnt_clr) begin
                r_rd_cnt    <= '0;
                r_wr_cnt    <= '0;
                r_mondo_cnt <= '0;
                r_pio_cnt   <= '0;
            end else begin
                r_rd_cnt    <= sat_inc(r_rd_cnt,    w_is_rd);
                r_wr_cnt    <= sat_inc(r_wr_cnt,    w_is_wr);
                r_mondo_cnt <= sat_inc(r_mondo_cnt, w_is_mondo);
                r_pio_cnt   <= sat_inc(r_pio_cnt,   w_is_pio);
            end

            r_err_pulse  <= w_err;
            r_err_sticky <= cnt_clr ? 4'b0000 : (r_err_sticky | w_err);
        end else begin
            r_err_pulse <= '0;
        end
    end

    assign rd_cnt       = r_rd_cnt;
    assign wr_cnt       = r_wr_cnt;
    assign mondo_cnt    = r_mondo_cnt;
    assign pio_cnt      = r_pio_cnt;
    assign credit_avail = r_credit;
    assign state        = r_state;
    assign err_pulse    = r_err_pulse;
    assign err_sticky   = r_err_sticky;

endmodule
